// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
//   Shared definitions for the push-button conditioner:
//     - rep_state_e   : per-channel auto-repeat FSM state encoding
//     - DEFAULT_*     : default timing for a 25 MHz clock
//     - max_int()     : elaboration-time helper used to size the repeat timer
//   Optional feature macro used by the top level: BUTTON_COND_LOCKOUT_EN.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    // Auto-repeat FSM states. The encodings are fixed so that state dumps
    // from the older per-switch debounce flow still read the same way.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_HELD   = 2'd3
    } rep_state_e;

    // Default timing at 25 MHz.
    localparam int DEFAULT_NUM_CH         = 4;
    localparam int DEFAULT_DEBOUNCE_LIMIT = 25000;     // 1 ms
    localparam int DEFAULT_REPEAT_DELAY   = 12500000;  // 0.5 s
    localparam int DEFAULT_REPEAT_PERIOD  = 2500000;   // 0.1 s

    // Larger of two integers, evaluated at elaboration time.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage : button_conditioner_pkg

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// button_conditioner_channel
//   One push-button channel: 2-FF synchroniser, debounce filter and the
//   hold-to-repeat FSM that produces press / release pulses.
//
//   Ports
//     clk        in   main clock
//     rst_n      in   asynchronous active-low reset
//     sw         in   raw switch, active high, asynchronous to clk
//     repeat_en  in   auto-repeat enable, sampled every cycle
//     sw_level   out  debounced level (registered)
//     sw_press   out  1-cycle pulse on accepted press and on each repeat
//     sw_release out  1-cycle pulse on accepted release
//
//   Timing: the debounced level changes DEBOUNCE_LIMIT+2 cycles after sw;
//   press/release pulses appear in the same cycle as the new level.
// -----------------------------------------------------------------------------
module button_conditioner_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw,
    input  logic repeat_en,
    output logic sw_level,
    output logic sw_press,
    output logic sw_release
);

    localparam int DB_CNT_W = $clog2(DEBOUNCE_LIMIT);
    localparam int TIMER_W  = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD));

    localparam logic [DB_CNT_W-1:0] DB_LAST     = DB_CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [TIMER_W-1:0]  DELAY_LAST  = TIMER_W'(REPEAT_DELAY - 1);
    localparam logic [TIMER_W-1:0]  PERIOD_LAST = TIMER_W'(REPEAT_PERIOD - 1);

    logic [1:0]          sync_r;
    logic [DB_CNT_W-1:0] db_cnt_r;
    logic                level_r;
    logic [TIMER_W-1:0]  timer_r;
    rep_state_e          state_r;
    logic                press_pulse_r;
    logic                rel_pulse_r;

    logic                mismatch_s;
    logic                accept_s;
    logic                rise_s;
    logic                fall_s;

    // Two-flop synchroniser; sync_r[1] is the metastability-safe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], sw};
        end
    end

    // Debounce decision: a new level is accepted on the DEBOUNCE_LIMIT-th
    // consecutive mismatching cycle. rise/fall are derived from the current
    // level so the FSM can react in the same edge that updates the level.
    always_comb begin
        mismatch_s = 1'b0;
        accept_s   = 1'b0;
        rise_s     = 1'b0;
        fall_s     = 1'b0;
        mismatch_s = sync_r[1] ^ level_r;
        accept_s   = mismatch_s && (db_cnt_r == DB_LAST);
        if (accept_s) begin
            rise_s = ~level_r;
            fall_s = level_r;
        end else begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end
    end

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_r <= '0;
            level_r  <= 1'b0;
        end else if (!mismatch_s) begin
            db_cnt_r <= '0;
        end else if (accept_s) begin
            db_cnt_r <= '0;
            level_r  <= ~level_r;
        end else begin
            db_cnt_r <= db_cnt_r + DB_CNT_W'(1);
        end
    end

    // Auto-repeat FSM with registered pulse outputs. An accepted fall is
    // checked first in every held state so that a release landing on a
    // timer expiry yields only the release pulse. Dropping repeat_en parks
    // the channel in HELD until release, even if repeat_en comes back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            timer_r       <= '0;
            press_pulse_r <= 1'b0;
            rel_pulse_r   <= 1'b0;
        end else begin
            press_pulse_r <= 1'b0;
            rel_pulse_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (rise_s) begin
                        press_pulse_r <= 1'b1;
                        timer_r       <= '0;
                        state_r       <= ST_DELAY;
                    end else begin
                        timer_r <= '0;
                    end
                end
                ST_DELAY: begin
                    if (fall_s) begin
                        rel_pulse_r <= 1'b1;
                        timer_r     <= '0;
                        state_r     <= ST_IDLE;
                    end else if (!repeat_en) begin
                        state_r <= ST_HELD;
                    end else if (timer_r == DELAY_LAST) begin
                        press_pulse_r <= 1'b1;
                        timer_r       <= '0;
                        state_r       <= ST_REPEAT;
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (fall_s) begin
                        rel_pulse_r <= 1'b1;
                        timer_r     <= '0;
                        state_r     <= ST_IDLE;
                    end else if (!repeat_en) begin
                        state_r <= ST_HELD;
                    end else if (timer_r == PERIOD_LAST) begin
                        press_pulse_r <= 1'b1;
                        timer_r       <= '0;
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_HELD: begin
                    if (fall_s) begin
                        rel_pulse_r <= 1'b1;
                        timer_r     <= '0;
                        state_r     <= ST_IDLE;
                    end else begin
                        timer_r <= '0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= '0;
                end
            endcase
        end
    end

    assign sw_level   = level_r;
    assign sw_press   = press_pulse_r;
    assign sw_release = rel_pulse_r;

endmodule : button_conditioner_channel

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   N-channel push-button front end feeding movement_player. Each channel is
//   an independent button_conditioner_channel (sync, debounce, auto-repeat).
//
//   Ports
//     CLK        in   main clock
//     RST_N      in   asynchronous active-low reset
//     SW         in   [NUM_CH] raw switches, active high, asynchronous
//     REPEAT_EN  in   [NUM_CH] per-channel auto-repeat enable
//     SW_LEVEL   out  [NUM_CH] debounced levels
//     SW_PRESS   out  [NUM_CH] press / repeat pulses
//     SW_RELEASE out  [NUM_CH] release pulses
//
//   Build option BUTTON_COND_LOCKOUT_EN: a channel's SW_PRESS is suppressed
//   in any cycle where another channel's SW_LEVEL is high, so the player
//   only ever moves in one direction. Levels, releases and FSMs are untouched.
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int NUM_CH         = DEFAULT_NUM_CH,
    parameter int DEBOUNCE_LIMIT = DEFAULT_DEBOUNCE_LIMIT,
    parameter int REPEAT_DELAY   = DEFAULT_REPEAT_DELAY,
    parameter int REPEAT_PERIOD  = DEFAULT_REPEAT_PERIOD
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NUM_CH-1:0] SW,
    input  logic [NUM_CH-1:0] REPEAT_EN,
    output logic [NUM_CH-1:0] SW_LEVEL,
    output logic [NUM_CH-1:0] SW_PRESS,
    output logic [NUM_CH-1:0] SW_RELEASE
);

    logic [NUM_CH-1:0] level_s;
    logic [NUM_CH-1:0] press_s;
    logic [NUM_CH-1:0] release_s;
    logic [NUM_CH-1:0] press_masked_s;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            button_conditioner_channel #(
                .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_channel (
                .clk        (CLK),
                .rst_n      (RST_N),
                .sw         (SW[g]),
                .repeat_en  (REPEAT_EN[g]),
                .sw_level   (level_s[g]),
                .sw_press   (press_s[g]),
                .sw_release (release_s[g])
            );
        end
    endgenerate

`ifdef BUTTON_COND_LOCKOUT_EN
    // Lockout: drop a press whenever any other channel is currently held.
    // Both operands are flop outputs, so the gating is glitch-free.
    always_comb begin
        logic [NUM_CH-1:0] others_v;
        press_masked_s = '0;
        others_v       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            others_v          = level_s & ~(NUM_CH'(1) << i);
            press_masked_s[i] = press_s[i] & ~(|others_v);
        end
    end
`else
    // Channels are independent: presses pass straight through.
    always_comb begin
        press_masked_s = '0;
        press_masked_s = press_s;
    end
`endif

    assign SW_LEVEL   = level_s;
    assign SW_PRESS   = press_masked_s;
    assign SW_RELEASE = release_s;

endmodule : button_conditioner

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Directed scenarios followed by randomized bouncing switches. The driver
//   applies inputs on the falling edge and pushes the reference model's
//   expected outputs for the next rising edge into a queue; the monitor pops
//   one entry per rising edge and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int NCH = 4;
    localparam int DL  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic           CLK;
    logic           RST_N;
    logic [NCH-1:0] SW;
    logic [NCH-1:0] REPEAT_EN;
    logic [NCH-1:0] SW_LEVEL;
    logic [NCH-1:0] SW_PRESS;
    logic [NCH-1:0] SW_RELEASE;

    button_conditioner #(
        .NUM_CH         (NCH),
        .DEBOUNCE_LIMIT (DL),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .SW         (SW),
        .REPEAT_EN  (REPEAT_EN),
        .SW_LEVEL   (SW_LEVEL),
        .SW_PRESS   (SW_PRESS),
        .SW_RELEASE (SW_RELEASE)
    );

    typedef struct packed {
        logic [NCH-1:0] lvl;
        logic [NCH-1:0] press;
        logic [NCH-1:0] rel;
    } resp_t;

    resp_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Driver-side requested inputs.
    logic [NCH-1:0] sw_v  = '0;
    logic [NCH-1:0] en_v  = '0;
    logic           rst_v = 1'b0;

    // Reference model: raw input history (two-edge transport delay), length of
    // the current disagreement run, accepted level, edges elapsed since the
    // accepted press, and whether repeats are still allowed for this hold.
    bit m_d1 [NCH];
    bit m_d2 [NCH];
    int m_run[NCH];
    bit m_lvl[NCH];
    int m_held[NCH];
    bit m_rep_ok[NCH];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_d1[c]     = 1'b0;
            m_d2[c]     = 1'b0;
            m_run[c]    = 0;
            m_lvl[c]    = 1'b0;
            m_held[c]   = 0;
            m_rep_ok[c] = 1'b0;
        end
    endtask

    // Expected outputs after one rising edge with the given inputs.
    task automatic model_step(input logic [NCH-1:0] sw_in,
                              input logic [NCH-1:0] en_in,
                              output resp_t r);
        bit seen;
        bit toggled;
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            seen    = m_d2[c];
            m_d2[c] = m_d1[c];
            m_d1[c] = sw_in[c];
            toggled = 1'b0;
            if (seen != m_lvl[c]) begin
                m_run[c] = m_run[c] + 1;
                if (m_run[c] == DL) begin
                    m_lvl[c] = ~m_lvl[c];
                    m_run[c] = 0;
                    toggled  = 1'b1;
                end
            end else begin
                m_run[c] = 0;
            end
            if (toggled && m_lvl[c]) begin
                r.press[c]  = 1'b1;
                m_held[c]   = 0;
                m_rep_ok[c] = 1'b1;
            end else if (toggled) begin
                r.rel[c] = 1'b1;
            end else if (m_lvl[c]) begin
                m_held[c] = m_held[c] + 1;
                if (!en_in[c]) begin
                    m_rep_ok[c] = 1'b0;
                end else if (m_rep_ok[c] && m_held[c] >= RD &&
                             ((m_held[c] - RD) % RP) == 0) begin
                    r.press[c] = 1'b1;
                end
            end
            r.lvl[c] = m_lvl[c];
        end
`ifdef BUTTON_COND_LOCKOUT_EN
        for (int c = 0; c < NCH; c++) begin
            for (int o = 0; o < NCH; o++) begin
                if (o != c && r.lvl[o]) begin
                    r.press[c] = 1'b0;
                end
            end
        end
`endif
    endtask

    // Apply the current requested inputs for n cycles, queueing expectations.
    task automatic drive(input int n);
        resp_t r;
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            SW        = sw_v;
            REPEAT_EN = en_v;
            RST_N     = rst_v;
            if (!rst_v) begin
                model_reset();
                r = '0;
                exp_q.push_back(r);
                #1;
                n_cmp++;
                if ({SW_LEVEL, SW_PRESS, SW_RELEASE} != '0) begin
                    n_bad++;
                    $display("FAIL async_reset t=%0t got lvl=%b press=%b rel=%b want all 0",
                             $time, SW_LEVEL, SW_PRESS, SW_RELEASE);
                end
            end else begin
                model_step(sw_v, en_v, r);
                exp_q.push_back(r);
            end
        end
    endtask

    // Monitor: one expected entry per rising edge, sampled 2 units after it.
    initial begin
        resp_t e;
        forever begin
            @(posedge CLK);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (SW_LEVEL !== e.lvl || SW_PRESS !== e.press || SW_RELEASE !== e.rel) begin
                    n_bad++;
                    $display("FAIL cycle_outputs t=%0t got lvl=%b press=%b rel=%b want lvl=%b press=%b rel=%b",
                             $time, SW_LEVEL, SW_PRESS, SW_RELEASE, e.lvl, e.press, e.rel);
                end
            end
        end
    end

    initial begin
        int cd[NCH];
        RST_N     = 1'b0;
        SW        = '0;
        REPEAT_EN = '0;
        model_reset();

        // Reset state.
        rst_v = 1'b0; drive(3);
        rst_v = 1'b1; en_v = 4'hF; sw_v = 4'h0; drive(3);

        // Long press with repeats, then release.
        sw_v[0] = 1'b1; drive(40);
        sw_v[0] = 1'b0; drive(12);

        // Short glitch on channel 1 is ignored.
        sw_v[1] = 1'b1; drive(3);
        sw_v[1] = 1'b0; drive(10);

        // Repeat disabled: single press and release.
        en_v = 4'h0;
        sw_v[2] = 1'b1; drive(40);
        sw_v[2] = 1'b0; drive(10);
        en_v = 4'hF;

        // Release accepted on the edge of a repeat expiry, then press again.
        sw_v[0] = 1'b1; drive(19);
        sw_v[0] = 1'b0; drive(10);
        sw_v[0] = 1'b1; drive(8);
        sw_v[0] = 1'b0; drive(10);

        // Repeat enable dropped mid-hold and restored: stays held.
        sw_v[1] = 1'b1; drive(12);
        en_v[1] = 1'b0; drive(2);
        en_v[1] = 1'b1; drive(20);
        sw_v[1] = 1'b0; drive(10);

        // Reset mid-hold; switch still high afterwards counts as a new press.
        sw_v[0] = 1'b1; drive(20);
        rst_v = 1'b0; drive(2);
        rst_v = 1'b1; drive(12);
        sw_v[0] = 1'b0; drive(10);

        // Channel 0 held, then channel 3 pressed (lockout interaction).
        sw_v[0] = 1'b1; drive(10);
        sw_v[3] = 1'b1; drive(15);
        sw_v = 4'h0; drive(12);

        // Simultaneous press on two channels.
        sw_v = 4'b0101; drive(15);
        sw_v = 4'h0; drive(12);

        // Randomized bouncing switches with occasional enable flips and resets.
        for (int c = 0; c < NCH; c++) begin
            cd[c] = $urandom_range(1, 20);
        end
        for (int t = 0; t < 4000; t++) begin
            for (int c = 0; c < NCH; c++) begin
                cd[c] = cd[c] - 1;
                if (cd[c] <= 0) begin
                    sw_v[c] = ~sw_v[c];
                    cd[c] = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 3)
                                                       : $urandom_range(5, 40);
                end
                if ($urandom_range(0, 39) == 0) begin
                    en_v[c] = ~en_v[c];
                end
            end
            rst_v = ($urandom_range(0, 1499) != 0);
            drive(1);
        end
        rst_v = 1'b1;
        sw_v  = 4'h0;
        drive(12);

        // Drain: every queued expectation must have been compared.
        repeat (2) @(posedge CLK);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain got %0d entries left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_button_conditioner
